// File: rtl/ram_arb_pkg.sv
// ============================================================================
// ram_arb_pkg : shared types and default widths for the RAM arbiter
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

endpackage : ram_arb_pkg

`default_nettype wire

// File: rtl/ram_arb_pick.sv
// ============================================================================
// ram_arb_pick : combinational two-way picker (fetch vs load/store)
// Config macro : RAM_ARB_RR_EN selects round-robin tie-break, else LS wins
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic if_valid_i,
    input  logic ls_valid_i,
    input  logic last_grant_i,
    output logic winner_o,
    output logic grant_o
);

`ifndef RAM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

    always_comb begin
        grant_o = if_valid_i | ls_valid_i;
        if (if_valid_i && ls_valid_i) begin
`ifdef RAM_ARB_RR_EN
            // The port not granted most recently takes the tie.
            winner_o = (last_grant_i == PORT_LS) ? PORT_IF : PORT_LS;
`else
            winner_o = PORT_LS;
`endif
        end else begin
            winner_o = ls_valid_i ? PORT_LS : PORT_IF;
        end
    end

endmodule : ram_arb_pick

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : shares a single-port sync RAM between fetch and load/store
// Config macro: RAM_ARB_RR_EN enables the round-robin last-grant pointer
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              ls_req_valid,
    input  logic              ls_req_write,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              id_q,    id_d;

    logic              winner;
    logic              grant;
    logic              last_grant;
    logic              in_idle;

    assign in_idle = (state_q == ST_IDLE);

    ram_arb_pick u_pick (
        .if_valid_i   (if_req_valid),
        .ls_valid_i   (ls_req_valid),
        .last_grant_i (last_grant),
        .winner_o     (winner),
        .grant_o      (grant)
    );

`ifdef RAM_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_IF;
        end else if (in_idle && grant) begin
            last_q <= winner;
        end
    end

    assign last_grant = last_q;
`else
    assign last_grant = PORT_IF;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            id_q    <= PORT_IF;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_ACCESS;
                    id_d    = winner;
                    if (winner == PORT_LS) begin
                        addr_d  = ls_req_addr;
                        wdata_d = ls_req_wdata;
                        write_d = ls_req_write;
                    end else begin
                        // Fetches leave the data pins holding their last value.
                        addr_d  = if_req_addr;
                        write_d = 1'b0;
                    end
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign if_req_ready = in_idle && grant && (winner == PORT_IF);
    assign ls_req_ready = in_idle && grant && (winner == PORT_LS);

    // Write strobe is decoded from state so an async reset drops it at once.
    assign ram_write = (state_q == ST_ACCESS) && write_q;
    assign ram_addr  = addr_q;
    assign ram_data  = wdata_q;

    assign if_rsp_valid = (state_q == ST_RESP) && (id_q == PORT_IF);
    assign ls_rsp_valid = (state_q == ST_RESP) && (id_q == PORT_LS);
    assign if_rsp_data  = if_rsp_valid ? ram_out : '0;
    assign ls_rsp_data  = (ls_rsp_valid && !write_q) ? ram_out : '0;

    assign busy = !in_idle;

endmodule : ram_arbiter

`default_nettype wire
